mic_fir_arbiter: RTL and testbench

//  Time-shares one AXI-stream anti-alias FIR between N_CH I2S mic channels.
//  - Captures each mic's valid-strobed sample and offers pending samples to the FIR round-robin.
//  - Tags every accepted sample with its channel ID and demuxes FIR results back to per-channel outputs.
//  - Sits between the i2s receivers and the downsamplers, replacing one FIR instance per mic.

---
 rtl/mic_fir_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mic_fir_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_fir_arbiter.sv
// mic_fir_arbiter
// Shares one AXI-stream anti-alias FIR between N_CH microphone channels.
// Each channel sample is held until it is offered to the FIR. Offers are
// granted round-robin. A tag FIFO records the channel of every accepted
// sample, so the FIR results (which return in order) can be steered back
// to the matching per-channel output.
`timescale 1ns/1ps
module mic_fir_arbiter #(
  parameter int N_CH      = 3,
  parameter int WIDTH     = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in_n,
  input  logic [N_CH-1:0]        ch_valid_in,
  input  logic [N_CH*WIDTH-1:0]  ch_data_in,
  output logic                   fir_tvalid_out,
  input  logic                   fir_tready_in,
  output logic [WIDTH-1:0]       fir_tdata_out,
  input  logic                   fir_res_valid_in,
  input  logic [WIDTH-1:0]       fir_res_data_in,
  output logic [N_CH-1:0]        ch_valid_out,
  output logic [N_CH*WIDTH-1:0]  ch_data_out,
  output logic [N_CH-1:0]        overrun_out,
  output logic                   tag_err_out
);

  localparam int CW = $clog2(N_CH);
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;

  // Capture side
  logic [WIDTH-1:0]    hold_r [N_CH];
  logic [N_CH-1:0]     pending_r;
  logic [N_CH-1:0]     overrun_r;

  // Offer side
  logic                tvalid_r;
  logic [WIDTH-1:0]    tdata_r;
  logic [CW-1:0]       sel_r;
  logic [CW-1:0]       last_grant_r;

  // Tag FIFO
  logic [CW-1:0]       tag_mem_r [TAG_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW:0]         count_r;

  // Return side
  logic [N_CH-1:0]     ch_valid_r;
  logic [N_CH*WIDTH-1:0] ch_data_r;
  logic                tag_err_r;

  // Combinational control
  logic                grant_valid_s;
  logic [CW-1:0]       grant_sel_s;
  logic                grant_fire_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CW-1:0]       pop_tag_s;

  assign fifo_full_s  = (count_r == (PW+1)'(TAG_DEPTH));
  assign fifo_empty_s = (count_r == '0);
  assign grant_fire_s = (state_r == ST_IDLE) && grant_valid_s && !fifo_full_s;
  assign push_s       = (state_r == ST_OFFER) && tvalid_r && fir_tready_in;
  assign pop_s        = fir_res_valid_in && !fifo_empty_s;
  assign pop_tag_s    = tag_mem_r[rd_ptr_r];

  // Round-robin scan: the first pending channel after last_grant wins
  always_comb begin : rr_scan
    int            idx_v;
    logic [CW-1:0] cand_v;
    grant_valid_s = 1'b0;
    grant_sel_s   = '0;
    idx_v         = 0;
    cand_v        = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx_v  = (int'(last_grant_r) + k) % N_CH;
      cand_v = CW'(idx_v);
      if (!grant_valid_s && pending_r[cand_v]) begin
        grant_valid_s = 1'b1;
        grant_sel_s   = cand_v;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: IDLE grants an offer, OFFER waits for the FIR handshake
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_fire_s) begin
          state_s = ST_OFFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (push_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OFFER;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Offer register: load on grant, hold through stalls, drop on handshake
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tvalid_r     <= 1'b0;
      tdata_r      <= '0;
      sel_r        <= '0;
      last_grant_r <= CW'(N_CH - 1);
    end else if (grant_fire_s) begin
      tvalid_r <= 1'b1;
      tdata_r  <= hold_r[grant_sel_s];
      sel_r    <= grant_sel_s;
    end else if (push_s) begin
      tvalid_r     <= 1'b0;
      last_grant_r <= sel_r;
    end
  end

  // Per-channel capture; a strobe on an un-offered pending sample is an overrun
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_r[i] <= '0;
      end
      pending_r <= '0;
      overrun_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_valid_in[i]) begin
          hold_r[i]    <= ch_data_in[i*WIDTH +: WIDTH];
          pending_r[i] <= 1'b1;
          if (pending_r[i] && !(grant_fire_s && (grant_sel_s == CW'(i)))) begin
            overrun_r[i] <= 1'b1;
          end
        end else if (grant_fire_s && (grant_sel_s == CW'(i))) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  // Tag FIFO: push the channel on every accepted offer, pop on every result
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= sel_r;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Result demux: steer each FIR result to its tagged channel, flag untagged results
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ch_valid_r <= '0;
      ch_data_r  <= '0;
      tag_err_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        ch_valid_r <= N_CH'(1'b1) << pop_tag_s;
        ch_data_r[int'(pop_tag_s)*WIDTH +: WIDTH] <= fir_res_data_in;
      end else begin
        ch_valid_r <= '0;
      end
      if (fir_res_valid_in && fifo_empty_s) begin
        tag_err_r <= 1'b1;
      end
    end
  end

  assign fir_tvalid_out = tvalid_r;
  assign fir_tdata_out  = tdata_r;
  assign ch_valid_out   = ch_valid_r;
  assign ch_data_out    = ch_data_r;
  assign overrun_out    = overrun_r;
  assign tag_err_out    = tag_err_r;

endmodule

// File: tb/tb_mic_fir_arbiter.sv
// Directed self-checking bench for mic_fir_arbiter (N_CH=3, WIDTH=16, TAG_DEPTH=8).
`timescale 1ns/1ps
module tb_mic_fir_arbiter;
  localparam int N_CH      = 3;
  localparam int WIDTH     = 16;
  localparam int TAG_DEPTH = 8;

  logic                  clk_in = 1'b0;
  logic                  rst_in_n;
  logic [N_CH-1:0]       ch_valid_in;
  logic [N_CH*WIDTH-1:0] ch_data_in;
  logic                  fir_tvalid_out;
  logic                  fir_tready_in;
  logic [WIDTH-1:0]      fir_tdata_out;
  logic                  fir_res_valid_in;
  logic [WIDTH-1:0]      fir_res_data_in;
  logic [N_CH-1:0]       ch_valid_out;
  logic [N_CH*WIDTH-1:0] ch_data_out;
  logic [N_CH-1:0]       overrun_out;
  logic                  tag_err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mic_fir_arbiter #(.N_CH(N_CH), .WIDTH(WIDTH), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk_in           (clk_in),
    .rst_in_n         (rst_in_n),
    .ch_valid_in      (ch_valid_in),
    .ch_data_in       (ch_data_in),
    .fir_tvalid_out   (fir_tvalid_out),
    .fir_tready_in    (fir_tready_in),
    .fir_tdata_out    (fir_tdata_out),
    .fir_res_valid_in (fir_res_valid_in),
    .fir_res_data_in  (fir_res_data_in),
    .ch_valid_out     (ch_valid_out),
    .ch_data_out      (ch_data_out),
    .overrun_out      (overrun_out),
    .tag_err_out      (tag_err_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    ch_data_in[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in_n         = 1'b0;
    ch_valid_in      = '0;
    ch_data_in       = '0;
    fir_tready_in    = 1'b0;
    fir_res_valid_in = 1'b0;
    fir_res_data_in  = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_in_n = 1'b1;
    #1;
    rst_in_n = 1'b0;
    #2;
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %h exp %h", fir_tvalid_out, 1'b0); end
    checks++; if (fir_tdata_out !== 16'h0000) begin errors++; $display("FAIL rst_tdata got %h exp %h", fir_tdata_out, 16'h0000); end
    checks++; if (ch_valid_out !== 3'b000) begin errors++; $display("FAIL rst_ch_valid got %b exp %b", ch_valid_out, 3'b000); end
    checks++; if (ch_data_out !== 48'h0) begin errors++; $display("FAIL rst_ch_data got %h exp %h", ch_data_out, 48'h0); end
    checks++; if (overrun_out !== 3'b000) begin errors++; $display("FAIL rst_overrun got %b exp %b", overrun_out, 3'b000); end
    checks++; if (tag_err_out !== 1'b0) begin errors++; $display("FAIL rst_tag_err got %b exp %b", tag_err_out, 1'b0); end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (2) tick();
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL rst_idle_tvalid got %h exp %h", fir_tvalid_out, 1'b0); end
  endtask

  task automatic test_single();
    apply_reset();
    fir_tready_in = 1'b1;
    ch_valid_in   = 3'b010;
    set_ch(1, 16'h1234);
    tick();
    ch_valid_in = 3'b000;
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL single_cyc1_tvalid got %h exp %h", fir_tvalid_out, 1'b0); end
    tick();
    checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL single_cyc2_tvalid got %h exp %h", fir_tvalid_out, 1'b1); end
    checks++; if (fir_tdata_out !== 16'h1234) begin errors++; $display("FAIL single_tdata got %h exp %h", fir_tdata_out, 16'h1234); end
    tick();
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL single_tvalid_drop got %h exp %h", fir_tvalid_out, 1'b0); end
    repeat (3) tick();
    fir_res_valid_in = 1'b1;
    fir_res_data_in  = 16'hABCD;
    tick();
    fir_res_valid_in = 1'b0;
    checks++; if (ch_valid_out !== 3'b010) begin errors++; $display("FAIL single_ch_valid got %b exp %b", ch_valid_out, 3'b010); end
    checks++; if (ch_data_out[16 +: 16] !== 16'hABCD) begin errors++; $display("FAIL single_ch1_data got %h exp %h", ch_data_out[16 +: 16], 16'hABCD); end
    tick();
    checks++; if (ch_valid_out !== 3'b000) begin errors++; $display("FAIL single_ch_valid_pulse got %b exp %b", ch_valid_out, 3'b000); end
    checks++; if (ch_data_out[16 +: 16] !== 16'hABCD) begin errors++; $display("FAIL single_ch1_hold got %h exp %h", ch_data_out[16 +: 16], 16'hABCD); end
  endtask

  task automatic test_round_robin();
    logic [15:0] acc[$];
    logic [15:0] exp1 [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [15:0] exp2 [2] = '{16'h4444, 16'h5555};
    logic [2:0]  exp_oh [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    apply_reset();
    fir_tready_in = 1'b1;
    ch_valid_in   = 3'b111;
    set_ch(0, 16'h1111); set_ch(1, 16'h2222); set_ch(2, 16'h3333);
    tick();
    ch_valid_in = 3'b000;
    for (int c = 0; c < 12; c++) begin
      if (fir_tvalid_out) acc.push_back(fir_tdata_out);
      tick();
    end
    checks++; if (acc.size() != 3) begin errors++; $display("FAIL rr_count1 got %0d exp %0d", acc.size(), 3); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= acc.size()) begin errors++; $display("FAIL rr_order1[%0d] got none exp %h", k, exp1[k]); end
      else if (acc[k] !== exp1[k]) begin errors++; $display("FAIL rr_order1[%0d] got %h exp %h", k, acc[k], exp1[k]); end
    end
    acc.delete();
    ch_valid_in = 3'b011;
    set_ch(0, 16'h4444); set_ch(1, 16'h5555);
    tick();
    ch_valid_in = 3'b000;
    for (int c = 0; c < 8; c++) begin
      if (fir_tvalid_out) acc.push_back(fir_tdata_out);
      tick();
    end
    checks++; if (acc.size() != 2) begin errors++; $display("FAIL rr_count2 got %0d exp %0d", acc.size(), 2); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= acc.size()) begin errors++; $display("FAIL rr_order2[%0d] got none exp %h", k, exp2[k]); end
      else if (acc[k] !== exp2[k]) begin errors++; $display("FAIL rr_order2[%0d] got %h exp %h", k, acc[k], exp2[k]); end
    end
    for (int k = 0; k < 5; k++) begin
      fir_res_valid_in = 1'b1;
      fir_res_data_in  = 16'hA000 + 16'(k);
      tick();
      checks++; if (ch_valid_out !== exp_oh[k]) begin errors++; $display("FAIL rr_demux[%0d] got %b exp %b", k, ch_valid_out, exp_oh[k]); end
    end
    fir_res_valid_in = 1'b0;
    tick();
    checks++; if (ch_valid_out !== 3'b000) begin errors++; $display("FAIL rr_demux_idle got %b exp %b", ch_valid_out, 3'b000); end
    checks++; if (ch_data_out[0 +: 16] !== 16'hA003) begin errors++; $display("FAIL rr_ch0_data got %h exp %h", ch_data_out[0 +: 16], 16'hA003); end
    checks++; if (ch_data_out[16 +: 16] !== 16'hA004) begin errors++; $display("FAIL rr_ch1_data got %h exp %h", ch_data_out[16 +: 16], 16'hA004); end
    checks++; if (ch_data_out[32 +: 16] !== 16'hA002) begin errors++; $display("FAIL rr_ch2_data got %h exp %h", ch_data_out[32 +: 16], 16'hA002); end
  endtask

  task automatic test_stall();
    apply_reset();
    fir_tready_in = 1'b0;
    ch_valid_in   = 3'b001;
    set_ch(0, 16'h0AAA);
    tick();
    ch_valid_in = 3'b000;
    tick();
    checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL stall_tvalid_start got %h exp %h", fir_tvalid_out, 1'b1); end
    for (int k = 0; k < 10; k++) begin
      ch_valid_in = (k == 3 || k == 6) ? 3'b001 : 3'b000;
      if (k == 3) set_ch(0, 16'h0BBB);
      if (k == 6) set_ch(0, 16'h0CCC);
      tick();
      checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL stall_tvalid[%0d] got %h exp %h", k, fir_tvalid_out, 1'b1); end
      checks++; if (fir_tdata_out !== 16'h0AAA) begin errors++; $display("FAIL stall_tdata[%0d] got %h exp %h", k, fir_tdata_out, 16'h0AAA); end
      if (k == 4) begin
        checks++; if (overrun_out !== 3'b000) begin errors++; $display("FAIL stall_no_overrun got %b exp %b", overrun_out, 3'b000); end
      end
      if (k == 6) begin
        checks++; if (overrun_out !== 3'b001) begin errors++; $display("FAIL stall_overrun got %b exp %b", overrun_out, 3'b001); end
      end
    end
    ch_valid_in   = 3'b000;
    fir_tready_in = 1'b1;
    tick();
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL stall_release got %h exp %h", fir_tvalid_out, 1'b0); end
    tick();
    checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL stall_reoffer got %h exp %h", fir_tvalid_out, 1'b1); end
    checks++; if (fir_tdata_out !== 16'h0CCC) begin errors++; $display("FAIL stall_latest_data got %h exp %h", fir_tdata_out, 16'h0CCC); end
    checks++; if (overrun_out !== 3'b001) begin errors++; $display("FAIL stall_overrun_sticky got %b exp %b", overrun_out, 3'b001); end
  endtask

  task automatic test_fifo_full();
    int hs = 0;
    bit saw_ch_valid = 1'b0;
    int r;
    apply_reset();
    fir_tready_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (fir_tvalid_out) hs++;
      if (ch_valid_out != 3'b000) saw_ch_valid = 1'b1;
      if (c == 0 || c == 6 || c == 12) begin
        r = c / 6;
        ch_valid_in = 3'b111;
        set_ch(0, 16'h4000 + 16'(r * 256));
        set_ch(1, 16'h4001 + 16'(r * 256));
        set_ch(2, 16'h4002 + 16'(r * 256));
      end else begin
        ch_valid_in = 3'b000;
      end
      tick();
    end
    checks++; if (hs != 8) begin errors++; $display("FAIL full_accepted got %0d exp %0d", hs, 8); end
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL full_tvalid_low got %h exp %h", fir_tvalid_out, 1'b0); end
    checks++; if (overrun_out !== 3'b000) begin errors++; $display("FAIL full_overrun got %b exp %b", overrun_out, 3'b000); end
    checks++; if (saw_ch_valid !== 1'b0) begin errors++; $display("FAIL full_spurious_ch_valid got %b exp %b", saw_ch_valid, 1'b0); end
    fir_res_valid_in = 1'b1;
    fir_res_data_in  = 16'h7777;
    tick();
    fir_res_valid_in = 1'b0;
    checks++; if (ch_valid_out !== 3'b001) begin errors++; $display("FAIL full_pop_ch_valid got %b exp %b", ch_valid_out, 3'b001); end
    checks++; if (ch_data_out[0 +: 16] !== 16'h7777) begin errors++; $display("FAIL full_pop_data got %h exp %h", ch_data_out[0 +: 16], 16'h7777); end
    tick();
    checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL full_resume_tvalid got %h exp %h", fir_tvalid_out, 1'b1); end
    checks++; if (fir_tdata_out !== 16'h4202) begin errors++; $display("FAIL full_resume_tdata got %h exp %h", fir_tdata_out, 16'h4202); end
  endtask

  task automatic test_tag_err();
    apply_reset();
    fir_res_valid_in = 1'b1;
    fir_res_data_in  = 16'h5A5A;
    tick();
    fir_res_valid_in = 1'b0;
    checks++; if (tag_err_out !== 1'b1) begin errors++; $display("FAIL tagerr_set got %b exp %b", tag_err_out, 1'b1); end
    checks++; if (ch_valid_out !== 3'b000) begin errors++; $display("FAIL tagerr_ch_valid got %b exp %b", ch_valid_out, 3'b000); end
    tick();
    checks++; if (ch_data_out !== 48'h0) begin errors++; $display("FAIL tagerr_ch_data got %h exp %h", ch_data_out, 48'h0); end
    checks++; if (tag_err_out !== 1'b1) begin errors++; $display("FAIL tagerr_sticky got %b exp %b", tag_err_out, 1'b1); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    fir_tready_in    = 1'b1;
    fir_res_valid_in = 1'b1;
    tick();
    fir_res_valid_in = 1'b0;
    ch_valid_in = 3'b010;
    set_ch(1, 16'h1111);
    tick();
    ch_valid_in = 3'b000;
    repeat (2) tick();
    fir_tready_in = 1'b0;
    ch_valid_in   = 3'b100;
    set_ch(2, 16'h2222);
    tick();
    ch_valid_in = 3'b000;
    tick();
    ch_valid_in = 3'b001;
    set_ch(0, 16'h0A0A);
    tick();
    set_ch(0, 16'h0B0B);
    tick();
    ch_valid_in      = 3'b000;
    fir_res_valid_in = 1'b1;
    fir_res_data_in  = 16'hBEEF;
    tick();
    fir_res_valid_in = 1'b0;
    checks++; if (fir_tdata_out !== 16'h2222) begin errors++; $display("FAIL mid_pre_tdata got %h exp %h", fir_tdata_out, 16'h2222); end
    checks++; if (ch_valid_out !== 3'b010) begin errors++; $display("FAIL mid_pre_ch_valid got %b exp %b", ch_valid_out, 3'b010); end
    checks++; if (overrun_out !== 3'b001) begin errors++; $display("FAIL mid_pre_overrun got %b exp %b", overrun_out, 3'b001); end
    checks++; if (tag_err_out !== 1'b1) begin errors++; $display("FAIL mid_pre_tag_err got %b exp %b", tag_err_out, 1'b1); end
    #2;
    rst_in_n = 1'b0;
    #1;
    checks++; if (fir_tvalid_out !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %h exp %h", fir_tvalid_out, 1'b0); end
    checks++; if (fir_tdata_out !== 16'h0000) begin errors++; $display("FAIL mid_tdata got %h exp %h", fir_tdata_out, 16'h0000); end
    checks++; if (ch_valid_out !== 3'b000) begin errors++; $display("FAIL mid_ch_valid got %b exp %b", ch_valid_out, 3'b000); end
    checks++; if (ch_data_out !== 48'h0) begin errors++; $display("FAIL mid_ch_data got %h exp %h", ch_data_out, 48'h0); end
    checks++; if (overrun_out !== 3'b000) begin errors++; $display("FAIL mid_overrun got %b exp %b", overrun_out, 3'b000); end
    checks++; if (tag_err_out !== 1'b0) begin errors++; $display("FAIL mid_tag_err got %b exp %b", tag_err_out, 1'b0); end
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in_n      = 1'b1;
    fir_tready_in = 1'b1;
    tick();
    ch_valid_in = 3'b101;
    set_ch(0, 16'h0C0C);
    set_ch(2, 16'h2C2C);
    tick();
    ch_valid_in = 3'b000;
    tick();
    checks++; if (fir_tvalid_out !== 1'b1) begin errors++; $display("FAIL mid_post_tvalid got %h exp %h", fir_tvalid_out, 1'b1); end
    checks++; if (fir_tdata_out !== 16'h0C0C) begin errors++; $display("FAIL mid_post_ch0_first got %h exp %h", fir_tdata_out, 16'h0C0C); end
  endtask

  initial begin
    ch_valid_in      = '0;
    ch_data_in       = '0;
    fir_tready_in    = 1'b0;
    fir_res_valid_in = 1'b0;
    fir_res_data_in  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_tag_err();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
